// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port data RAM: owner FSM with burst limit, lock and read return.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise master 0 has fixed priority on ties.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        owner_o
);

  localparam int unsigned     CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  // Encoding doubles as the owner_o status code.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e            state_q, state_d, other_st;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              rd_pending_q, rd_master_q;
  logic              own_is1, own_req, own_we, own_lock, oth_req;
  logic              xfer, burst_done, idle_pick1;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_q;  // 1 when master 1 was the most recent owner
  assign idle_pick1 = m1_req && (!m0_req || !last_q);
`else
  assign idle_pick1 = m1_req && !m0_req;
`endif

  // View of the current owner and its competitor.
  always_comb begin
    own_is1    = (state_q == StOwn1);
    own_req    = own_is1 ? m1_req   : m0_req;
    own_we     = own_is1 ? m1_we    : m0_we;
    own_lock   = own_is1 ? m1_lock  : m0_lock;
    own_addr   = own_is1 ? m1_addr  : m0_addr;
    own_wdata  = own_is1 ? m1_wdata : m0_wdata;
    oth_req    = own_is1 ? m0_req   : m1_req;
    other_st   = own_is1 ? StOwn0   : StOwn1;
    xfer       = (state_q != StIdle) && own_req;
    cnt_inc    = (xfer && (cnt_q != CntMax)) ? cnt_q + CntW'(1) : cnt_q;
    burst_done = !own_lock && oth_req && (cnt_inc == CntMax);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) state_d = idle_pick1 ? StOwn1 : StOwn0;
      end
      StOwn0, StOwn1: begin
        if (!own_req)        state_d = oth_req ? other_st : StIdle;
        else if (burst_done) state_d = other_st;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = ((state_q == StIdle) || (state_d != state_q) || !oth_req) ? '0 : cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      rd_master_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= xfer && !own_we;
      if (xfer) rd_master_q <= own_is1;
`ifdef MEM_ARB_RR_EN
      if ((state_d != state_q) && (state_d != StIdle)) last_q <= (state_d == StOwn1);
`endif
    end
  end

  // Reset forces every output quiet in the same cycle, dropping any in-flight read.
  always_comb begin
    m0_gnt      = !rst && (state_q == StOwn0) && m0_req;
    m1_gnt      = !rst && (state_q == StOwn1) && m1_req;
    ram_we_o    = !rst && xfer && own_we;
    ram_addr_o  = (!rst && (state_q != StIdle)) ? own_addr  : '0;
    ram_wdata_o = (!rst && (state_q != StIdle)) ? own_wdata : '0;
    owner_o     = rst ? 2'b00 : state_q;
    m0_rvalid   = !rst && rd_pending_q && !rd_master_q;
    m1_rvalid   = !rst && rd_pending_q && rd_master_q;
    m0_rdata    = m0_rvalid ? ram_rdata_i : '0;
    m1_rdata    = m1_rvalid ? ram_rdata_i : '0;
  end

endmodule
